// File: rtl/vi_ddr_wr_ctrl.sv
// Write-side DDR burst controller: drains the video-input FIFO into fixed-length
// write bursts and rotates across BUF_NUM frame buffers.
module vi_ddr_wr_ctrl #(
    parameter int          DATA_W      = 128,
    parameter int          CNT_W       = 10,
    parameter int          ADDR_W      = 28,
    parameter int          BURST_LEN   = 64,
    parameter int          FRAME_BEATS = 518400,
    parameter int          BUF_NUM     = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] BUF_STRIDE  = 32'h0080_0000
) (
    input  logic              ui_clk,
    input  logic              ui_rst,
    input  logic              frame_start,
    input  logic [CNT_W-1:0]  rd_data_count,
    output logic              pkg_wr_en,
    input  logic [DATA_W-1:0] pkg_wr_data,
    output logic              wr_burst_req,
    output logic [9:0]        wr_burst_len,
    output logic [ADDR_W-1:0] wr_burst_addr,
    input  logic              wr_burst_data_req,
    output logic [DATA_W-1:0] wr_burst_data,
    input  logic              wr_burst_finish,
    output logic [1:0]        wr_buf_idx,
    output logic [1:0]        last_buf_idx,
    output logic              frame_done,
    output logic              frame_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_DATA} state_t;

    localparam logic [19:0] FRAME_LEN = 20'(FRAME_BEATS);
    localparam logic [19:0] BURST_MAX = 20'(BURST_LEN);
    localparam logic [1:0]  LAST_BUF  = 2'(BUF_NUM - 1);

    state_t            r_state;
    logic [19:0]       r_offset;
    logic [19:0]       r_remaining;
    logic              r_pending;

    logic [19:0]       w_len;
    logic [19:0]       w_offset_nxt;
    logic [19:0]       w_remaining_nxt;
    logic [1:0]        w_buf_nxt;
    logic [ADDR_W-1:0] w_addr;
    logic              w_active;
    logic              w_finish;
    logic              w_pend;

    // NOTE: the FIFO pop is a direct gate of the controller's beat request so the
    // FIFO's one-cycle read latency lines up with the controller's next-cycle data.
    assign w_active      = (r_state == S_REQ) || (r_state == S_DATA);
    assign pkg_wr_en     = w_active && wr_burst_data_req;
    assign wr_burst_data = pkg_wr_data;

    assign w_len           = (r_remaining < BURST_MAX) ? r_remaining : BURST_MAX;
    assign w_offset_nxt    = r_offset + 20'(wr_burst_len);
    assign w_remaining_nxt = r_remaining - 20'(wr_burst_len);
    assign w_buf_nxt       = (wr_buf_idx == LAST_BUF) ? 2'd0 : wr_buf_idx + 2'd1;
    assign w_addr          = ADDR_W'(BASE_ADDR)
                           + ADDR_W'(wr_buf_idx) * ADDR_W'(BUF_STRIDE)
                           + ADDR_W'({r_offset, 4'b0000});

    // A single-beat burst may see its only request and the finish together in REQ.
    assign w_finish = wr_burst_finish &&
                      ((r_state == S_DATA) || ((r_state == S_REQ) && wr_burst_data_req));
    assign w_pend   = r_pending || frame_start;

    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            r_state       <= S_IDLE;
            r_offset      <= '0;
            r_remaining   <= '0;
            r_pending     <= 1'b0;
            wr_burst_req  <= 1'b0;
            wr_burst_len  <= '0;
            wr_burst_addr <= '0;
            wr_buf_idx    <= '0;
            last_buf_idx  <= '0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pend) begin
                        r_offset    <= '0;
                        r_remaining <= FRAME_LEN;
                        r_pending   <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (frame_start && (r_remaining != FRAME_LEN)) begin
                        frame_err   <= 1'b1;
                        wr_buf_idx  <= w_buf_nxt;
                        r_offset    <= '0;
                        r_remaining <= FRAME_LEN;
                    end else if (20'(rd_data_count) >= w_len) begin
                        wr_burst_len  <= 10'(w_len);
                        wr_burst_addr <= w_addr;
                        wr_burst_req  <= 1'b1;
                        r_state       <= S_REQ;
                    end
                end
                S_REQ, S_DATA: begin
                    if (frame_start) r_pending <= 1'b1;
                    if ((r_state == S_REQ) && wr_burst_data_req) begin
                        wr_burst_req <= 1'b0;
                        r_state      <= S_DATA;
                    end
                    if (w_finish) begin
                        r_offset    <= w_offset_nxt;
                        r_remaining <= w_remaining_nxt;
                        if (w_remaining_nxt == '0) begin
                            // A start seen during this burst stays pending and
                            // launches the next frame from IDLE.
                            frame_done   <= 1'b1;
                            last_buf_idx <= wr_buf_idx;
                            wr_buf_idx   <= w_buf_nxt;
                            r_state      <= S_IDLE;
                        end else if (w_pend) begin
                            frame_err   <= 1'b1;
                            wr_buf_idx  <= w_buf_nxt;
                            r_offset    <= '0;
                            r_remaining <= FRAME_LEN;
                            r_pending   <= 1'b0;
                            r_state     <= S_WAIT;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vi_ddr_wr_ctrl.sv
// Self-checking bench for vi_ddr_wr_ctrl: randomized controller handshakes against
// a frame-level behavioural model, plus literal burst/buffer expectations.
module tb_vi_ddr_wr_ctrl;

    localparam int          FB     = 200;
    localparam int          BL     = 64;
    localparam int          BN     = 3;
    localparam int          BASE   = 0;
    localparam int          STRIDE = 'h0080_0000;

    logic         ui_clk = 1'b0;
    logic         ui_rst = 1'b1;
    logic         frame_start = 1'b0;
    logic [9:0]   rd_data_count = 10'd100;
    logic         pkg_wr_en;
    logic [127:0] pkg_wr_data = '0;
    logic         wr_burst_req;
    logic [9:0]   wr_burst_len;
    logic [27:0]  wr_burst_addr;
    logic         wr_burst_data_req = 1'b0;
    logic [127:0] wr_burst_data;
    logic         wr_burst_finish = 1'b0;
    logic [1:0]   wr_buf_idx;
    logic [1:0]   last_buf_idx;
    logic         frame_done;
    logic         frame_err;

    vi_ddr_wr_ctrl #(
        .DATA_W(128), .CNT_W(10), .ADDR_W(28), .BURST_LEN(BL), .FRAME_BEATS(FB),
        .BUF_NUM(BN), .BASE_ADDR(32'h0), .BUF_STRIDE(32'h0080_0000)
    ) dut (
        .ui_clk(ui_clk), .ui_rst(ui_rst), .frame_start(frame_start),
        .rd_data_count(rd_data_count), .pkg_wr_en(pkg_wr_en), .pkg_wr_data(pkg_wr_data),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
        .wr_burst_addr(wr_burst_addr), .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_data(wr_burst_data), .wr_burst_finish(wr_burst_finish),
        .wr_buf_idx(wr_buf_idx), .last_buf_idx(last_buf_idx),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 ui_clk = ~ui_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Standard FIFO: sequential words, one-cycle read latency.
    int unsigned fifo_ctr = 0;
    always @(posedge ui_clk) begin
        if (pkg_wr_en) begin
            pkg_wr_data <= 128'(fifo_ctr);
            fifo_ctr    <= fifo_ctr + 1;
        end
    end

    // Frame-level reference: beats written so far, buffer indices, burst in flight.
    bit          m_active, m_req, m_data, m_pending, exp_done, exp_err, prev_en;
    int          m_done, m_nl;
    logic [1:0]  m_buf, m_last;
    logic [9:0]  m_len;
    logic [27:0] m_addr;
    int unsigned exp_data = 0;
    int          n_data = 0, n_en = 0, n_done = 0, n_err = 0;

    always @(negedge ui_clk) begin
        if (prev_en) begin
            check("beat_data", wr_burst_data[63:0], 64'(exp_data));
            exp_data++;
            n_data++;
        end
        prev_en = pkg_wr_en;
        n_en += int'(pkg_wr_en);
        if (ui_rst) begin
            check("rst_req", 64'(wr_burst_req), 64'd0);
            check("rst_en", 64'(pkg_wr_en), 64'd0);
            check("rst_len", 64'(wr_burst_len), 64'd0);
            check("rst_addr", 64'(wr_burst_addr), 64'd0);
            check("rst_buf", 64'(wr_buf_idx), 64'd0);
            check("rst_last", 64'(last_buf_idx), 64'd0);
            check("rst_done", 64'(frame_done), 64'd0);
            check("rst_err", 64'(frame_err), 64'd0);
            m_active = 0; m_req = 0; m_data = 0; m_pending = 0;
            exp_done = 0; exp_err = 0; m_done = 0; m_buf = 0; m_last = 0;
        end else begin
            check("req", 64'(wr_burst_req), 64'(m_req));
            if (m_req || m_data) begin
                check("len", 64'(wr_burst_len), 64'(m_len));
                check("addr", 64'(wr_burst_addr), 64'(m_addr));
            end
            check("frame_done", 64'(frame_done), 64'(exp_done));
            check("frame_err", 64'(frame_err), 64'(exp_err));
            check("wr_buf", 64'(wr_buf_idx), 64'(m_buf));
            check("last_buf", 64'(last_buf_idx), 64'(m_last));
            check("pkg_wr_en", 64'(pkg_wr_en), 64'(wr_burst_data_req && (m_req || m_data)));
            n_done += int'(frame_done);
            n_err  += int'(frame_err);

            // Advance the model by what the coming clock edge will consume.
            exp_done = 0;
            exp_err  = 0;
            if (m_req || m_data) begin
                if (frame_start) m_pending = 1;
                if (m_req && wr_burst_data_req) begin
                    m_req  = 0;
                    m_data = 1;
                end else if (m_data && wr_burst_finish) begin
                    m_data = 0;
                    m_done += int'(m_len);
                    if (m_done == FB) begin
                        exp_done = 1;
                        m_last   = m_buf;
                        m_buf    = 2'((int'(m_buf) + 1) % BN);
                        m_active = 0;
                    end else if (m_pending) begin
                        exp_err   = 1;
                        m_buf     = 2'((int'(m_buf) + 1) % BN);
                        m_done    = 0;
                        m_pending = 0;
                    end
                end
            end else if (m_active) begin
                m_nl = (FB - m_done < BL) ? FB - m_done : BL;
                if (frame_start && m_done != 0) begin
                    exp_err = 1;
                    m_buf   = 2'((int'(m_buf) + 1) % BN);
                    m_done  = 0;
                end else if (int'(rd_data_count) >= m_nl) begin
                    m_req  = 1;
                    m_len  = 10'(m_nl);
                    m_addr = 28'(BASE + int'(m_buf) * STRIDE + m_done * 16);
                end
            end else if (frame_start || m_pending) begin
                m_active  = 1;
                m_done    = 0;
                m_pending = 0;
            end
        end
    end

    task automatic cyc(input logic fs, input logic dr, input logic fin);
        frame_start       = fs;
        wr_burst_data_req = dr;
        wr_burst_finish   = fin;
        @(posedge ui_clk);
        #2;
        frame_start       = 1'b0;
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;
    endtask

    // Plays the memory controller for one burst; fs_at/rst_at pick a beat at which
    // to pulse frame_start or assert reset (-1 for neither).
    task automatic run_burst(input int fs_at, input int rst_at,
                             output logic [27:0] addr, output logic [9:0] len);
        int n;
        bit fin_same;
        for (int i = 0; i < 300 && !wr_burst_req; i++) cyc(0, 0, 0);
        check("req_seen", 64'(wr_burst_req), 64'd1);
        addr = wr_burst_addr;
        len  = wr_burst_len;
        if (!wr_burst_req) return;
        repeat ($urandom_range(0, 2)) cyc(0, 0, 0);
        n = int'(len);
        fin_same = 0;
        for (int b = 0; b < n; b++) begin
            repeat ($urandom_range(0, 2)) cyc(0, 0, 0);
            if (b == rst_at) begin
                ui_rst = 1'b1;
                wr_burst_data_req = 1'b1;
                #1;
                check("rst_req_async", 64'(wr_burst_req), 64'd0);
                check("rst_en_async", 64'(pkg_wr_en), 64'd0);
                check("rst_buf_async", 64'(wr_buf_idx), 64'd0);
                wr_burst_data_req = 1'b0;
                repeat (3) cyc(0, 0, 0);
                ui_rst = 1'b0;
                return;
            end
            fin_same = (b == n - 1) && ($urandom_range(0, 1) == 1);
            cyc(b == fs_at, 1'b1, fin_same);
        end
        if (!fin_same) begin
            repeat ($urandom_range(0, 2)) cyc(0, 0, 0);
            cyc(0, 0, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] a;
        logic [9:0]  l;
        logic [27:0] f1_addr [4] = '{28'h000, 28'h400, 28'h800, 28'hC00};
        logic [9:0]  f1_len  [4] = '{10'd64, 10'd64, 10'd64, 10'd8};
        logic [27:0] rot_addr[3] = '{28'h080_0000, 28'h100_0000, 28'h000_0000};
        logic [1:0]  rot_last[3] = '{2'd1, 2'd2, 2'd0};
        logic [27:0] first_a;

        repeat (3) cyc(0, 0, 0);
        ui_rst = 1'b0;
        cyc(0, 0, 0);
        check("init_buf", 64'(wr_buf_idx), 64'd0);
        check("init_last", 64'(last_buf_idx), 64'd0);

        // Single full frame into buffer 0.
        cyc(1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            run_burst(-1, -1, a, l);
            check($sformatf("f1_addr%0d", k), 64'(a), 64'(f1_addr[k]));
            check($sformatf("f1_len%0d", k), 64'(l), 64'(f1_len[k]));
        end
        repeat (2) cyc(0, 0, 0);
        check("f1_done_count", 64'(n_done), 64'd1);
        check("f1_last", 64'(last_buf_idx), 64'd0);
        check("f1_wrbuf", 64'(wr_buf_idx), 64'd1);
        check("f1_pops", 64'(n_en), 64'd200);
        check("f1_beats", 64'(n_data), 64'd200);

        // Buffer rotation across three more frames.
        for (int f = 0; f < 3; f++) begin
            cyc(1, 0, 0);
            for (int k = 0; k < 4; k++) begin
                run_burst(-1, -1, a, l);
                if (k == 0) first_a = a;
            end
            repeat (2) cyc(0, 0, 0);
            check($sformatf("rot_addr%0d", f), 64'(first_a), 64'(rot_addr[f]));
            check($sformatf("rot_last%0d", f), 64'(last_buf_idx), 64'(rot_last[f]));
        end

        // Starvation, then release by one word.
        rd_data_count = 10'd63;
        cyc(1, 0, 0);
        repeat (30) begin
            cyc(0, 0, 0);
            check("starve_req", 64'(wr_burst_req), 64'd0);
        end
        rd_data_count = 10'd64;
        cyc(0, 0, 0);
        check("starve_release", 64'(wr_burst_req), 64'd1);
        rd_data_count = 10'd100;
        run_burst(-1, -1, a, l);
        check("starve_addr", 64'(a), 64'h080_0000);
        run_burst(-1, -1, a, l);
        check("b2_addr", 64'(a), 64'h080_0400);

        // Early frame_start while starved in WAIT.
        rd_data_count = 10'd0;
        cyc(1, 0, 0);
        check("wait_abort_err", 64'(frame_err), 64'd1);
        check("wait_abort_last", 64'(last_buf_idx), 64'd0);
        check("wait_abort_buf", 64'(wr_buf_idx), 64'd2);
        rd_data_count = 10'd100;
        run_burst(-1, -1, a, l);
        check("after_abort_addr", 64'(a), 64'h100_0000);
        check("after_abort_len", 64'(l), 64'd64);

        // Early frame_start during DATA: abort lands after the finish.
        run_burst(10, -1, a, l);
        check("data_abort_err", 64'(frame_err), 64'd1);
        check("data_abort_last", 64'(last_buf_idx), 64'd0);
        run_burst(-1, -1, a, l);
        check("data_abort_addr", 64'(a), 64'h000_0000);
        check("data_abort_len", 64'(l), 64'd64);
        run_burst(-1, -1, a, l);
        run_burst(-1, -1, a, l);

        // Start during the final burst: completion, then automatic next frame.
        run_burst(3, -1, a, l);
        check("pend_last_len", 64'(l), 64'd8);
        run_burst(-1, -1, a, l);
        check("pend_next_addr", 64'(a), 64'h080_0000);
        check("pend_last_buf", 64'(last_buf_idx), 64'd0);

        // Reset mid-burst while buffer 1 is active.
        run_burst(-1, 5, a, l);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            run_burst(-1, -1, a, l);
            if (k == 0) first_a = a;
        end
        repeat (2) cyc(0, 0, 0);
        check("post_rst_addr", 64'(first_a), 64'h000_0000);
        check("post_rst_last", 64'(last_buf_idx), 64'd0);
        check("post_rst_buf", 64'(wr_buf_idx), 64'd1);

        repeat (4) cyc(0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vi_ddr_wr_ctrl.md
# vi_ddr_wr_ctrl

Write-side burst controller in the `ui_clk` domain, directly downstream of the video-input width-conversion FIFO. It watches the FIFO's `rd_data_count`, and once enough 128-bit words are buffered it issues fixed-length DDR write bursts to the memory-controller user port. It drains the FIFO through `pkg_wr_en`/`pkg_wr_data`, walks the write address through a frame, and rotates across `BUF_NUM` frame buffers so the read-side pipeline always has one completed frame.

## Interface
Parameters:
- `DATA_W`, 128: FIFO read / DDR data width in bits.
- `CNT_W`, 10: width of the FIFO `rd_data_count`.
- `ADDR_W`, 28: DDR byte-address width.
- `BURST_LEN`, 64: beats per full burst (1..511).
- `FRAME_BEATS`, 518400: 128-bit beats per frame (1920x1080x32 bit / 128).
- `BUF_NUM`, 3: number of frame buffers (2..4).
- `BASE_ADDR`, 0: byte address of buffer 0.
- `BUF_STRIDE`, 32'h0080_0000: byte distance between buffers.

Ports (clock and reset first):
- `ui_clk`, in, 1: the single clock for the block.
- `ui_rst`, in, 1: asynchronous, active-high reset.
- `frame_start`, in, 1: one-cycle pulse at the start of input frame, already synchronised to `ui_clk`.
- `rd_data_count`, in, CNT_W: FIFO read-side word count.
- `pkg_wr_en`, out, 1: FIFO read enable.
- `pkg_wr_data`, in, DATA_W: FIFO dout, valid one cycle after `pkg_wr_en` (standard, non-FWFT FIFO).
- `wr_burst_req`, out, 1: burst request to the memory controller.
- `wr_burst_len`, out, 10: beats in the current burst.
- `wr_burst_addr`, out, ADDR_W: burst start byte address.
- `wr_burst_data_req`, in, 1: controller requests one beat; data is expected on the next cycle.
- `wr_burst_data`, out, DATA_W: beat data.
- `wr_burst_finish`, in, 1: one-cycle pulse when the burst completes.
- `wr_buf_idx`, out, 2: buffer currently being written.
- `last_buf_idx`, out, 2: most recently completed buffer, for the read side.
- `frame_done`, out, 1: one-cycle pulse when a frame completes.
- `frame_err`, out, 1: one-cycle pulse when a frame is aborted by an early `frame_start`.

## Operation
States:
- **IDLE**: wait for `frame_start` (or a pending start). Clear `offset` and set `remaining = FRAME_BEATS`. Go to WAIT.
- **WAIT**: compute `len = min(BURST_LEN, remaining)`. When `rd_data_count >= len`, latch `wr_burst_len = len` and `wr_burst_addr = BASE_ADDR + wr_buf_idx*BUF_STRIDE + offset*16`, then go to REQ.
- **REQ**: hold `wr_burst_req` = 1. On the first `wr_burst_data_req`, drop `wr_burst_req` and go to DATA.
- **DATA**: wait for `wr_burst_finish`. Then update `offset += len` and `remaining -= len`.
  - If `remaining` reaches 0: pulse `frame_done`, set `last_buf_idx = wr_buf_idx`, advance `wr_buf_idx` (wraps from `BUF_NUM-1` to 0), go to IDLE.
  - Otherwise go to WAIT.

Data path:
- `pkg_wr_en = wr_burst_data_req`, combinationally, in REQ and DATA only; 0 in all other states.
- `wr_burst_data = pkg_wr_data`, passed straight through. The FIFO's one-cycle latency provides the next-cycle data timing.

Arithmetic:
- `offset` is 20 bits, `remaining` is 20 bits, address arithmetic is `ADDR_W` bits.
- Address overflow wraps modulo 2^ADDR_W. There is no range check.

`frame_start` handling:
- In IDLE: start immediately.
- In WAIT with `remaining != FRAME_BEATS`: abort. Pulse `frame_err`, advance `wr_buf_idx` without updating `last_buf_idx`, and restart at `offset` 0.
- In REQ or DATA: latch as pending. After `wr_burst_finish`, apply the WAIT abort rule. If that burst also completed the frame, do a normal completion, then start the next frame from the pending start.
- `frame_start` in WAIT with `remaining == FRAME_BEATS` is ignored.

Other rules:
- A `wr_burst_data_req` outside REQ/DATA is ignored and does not pop the FIFO.
- The last burst of a frame is short when `FRAME_BEATS` is not a multiple of `BURST_LEN`.

## Timing
- Reset values: all outputs 0, with `wr_buf_idx` = 0 and `last_buf_idx` = 0. State IDLE, no pending start.
- Reset mid-burst returns the block to IDLE at once. `wr_burst_req` and `pkg_wr_en` drop asynchronously.
- Latency:
  - `frame_start` to WAIT: 1 cycle.
  - WAIT condition true to `wr_burst_req` high: 1 cycle, with `wr_burst_len` and `wr_burst_addr` stable from that same cycle until `wr_burst_finish`.
  - `wr_burst_finish` to the next `wr_burst_req`: at least 2 cycles (DATA→WAIT→REQ).
  - `frame_done` and `frame_err`: asserted the cycle after `wr_burst_finish`, or after the `frame_start` for an abort in WAIT.
- `wr_burst_data_req` and `wr_burst_finish` arriving in the same cycle: the beat is popped, and the finish is processed.

## Test plan
- **Single full frame**: `FRAME_BEATS`=200, `BURST_LEN`=64, count held at 100 → bursts of 64, 64, 64, 8 at addresses 0x000, 0x400, 0x800, 0xC00; `frame_done` fires once; `last_buf_idx` = 0; `wr_buf_idx` = 1.
- **Starvation**: count stuck at 63 with `BURST_LEN`=64 → `wr_burst_req` never asserts. Raising count to 64 → `wr_burst_req` high exactly 1 cycle later.
- **Data alignment**: FIFO model returns sequential 0,1,2,… with one-cycle latency; controller requests beats with random gaps → `wr_burst_data` captured is 0..199 in order; exactly 200 `pkg_wr_en` pulses.
- **Buffer rotation**: 4 frames with `BUF_NUM`=3 → burst addresses start at 0x0, 0x800000, 0x1000000, 0x0; `last_buf_idx` sequence 0, 1, 2, 0.
- **Early frame_start**: pulse after 2 of 4 bursts, while in WAIT → `frame_err` pulse, `last_buf_idx` unchanged, next burst at buffer-1 base with `wr_burst_len` 64. Pulse during DATA → abort applied after `wr_burst_finish`.
- **Reset mid-burst**: assert `ui_rst` during DATA → `wr_burst_req`, `pkg_wr_en` and `wr_buf_idx` read 0 in the same cycle; after release, the next `frame_start` writes from 0x0.
